// File: rtl/dma_bus_responder.sv
// Memory-backed target for the shared DMA transaction bus: answers single and
// burst read/write transactions that fall inside a 2^MEM_WORDS_LOG2-word window.
module dma_bus_responder #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h5000_0000,
  parameter int unsigned MEM_WORDS_LOG2 = 8,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic        end_transaction_in,
  input  logic        read_n_write_in,
  input  logic [31:0] address_data_in,
  input  logic [7:0]  burst_size_in,
  input  logic [3:0]  byte_enables_in,
  input  logic        data_valid_in,
  input  logic        busy_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int unsigned AW        = MEM_WORDS_LOG2;
  localparam int unsigned MEM_WORDS = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = 1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WRITE      = 3'd1;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd2;
  localparam logic [2:0] ST_READ_FETCH = 3'd3;
  localparam logic [2:0] ST_READ_DATA  = 3'd4;
  localparam logic [2:0] ST_READ_END   = 3'd5;
  localparam logic [2:0] ST_ERROR      = 3'd6;

  logic [31:0] mem [MEM_WORDS];

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    rem_q, rem_d;
  logic          done_q, done_d;
  logic [3:0]    be_q, be_d;
  logic [3:0]    wait_q, wait_d;
  logic [31:0]   data_q, data_d;
  logic          dvalid_q, dvalid_d;
  logic          endt_q, endt_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic          mem_we;

  logic          hit;
  logic          begin_err;
  logic [AW-1:0] start_idx;
  logic [32:0]   last_idx;

  assign hit       = address_data_in[31:AW+2] == BASE_ADDRESS[31:AW+2];
  assign start_idx = address_data_in[AW+1:2];
  assign last_idx  = 33'(start_idx) + 33'(burst_size_in);
  assign begin_err = (address_data_in[1:0] != 2'b00) || (last_idx > 33'(MEM_WORDS - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    done_d   = done_q;
    be_d     = be_q;
    wait_d   = wait_q;
    data_d   = data_q;
    dvalid_d = dvalid_q;
    endt_d   = endt_q;
    busy_d   = busy_q;
    error_d  = error_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (begin_transaction_in && hit) begin
          if (begin_err) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            ptr_d   = start_idx;
            rem_d   = burst_size_in;
            done_d  = 1'b0;
            be_d    = byte_enables_in;
            state_d = read_n_write_in ? ST_READ_FETCH : ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (data_valid_in) begin
          // done_q marks that the beat for remaining==0 was already taken
          if (done_q) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PTR_ONE;
            if (rem_q == 8'd0) done_d = 1'b1;
            else               rem_d  = rem_q - 8'd1;
            if (end_transaction_in) begin
              state_d = ST_IDLE;
            end else if (WAIT_STATES != 0) begin
              state_d = ST_WRITE_WAIT;
              busy_d  = 1'b1;
              wait_d  = 4'(WAIT_STATES - 1);
            end
          end
        end else if (end_transaction_in) begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE_WAIT: begin
        if (end_transaction_in) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (wait_q == 4'd0) begin
          state_d = ST_WRITE;
          busy_d  = 1'b0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      // The read pointer runs one word ahead of the beat on the bus, so the
      // data register always reloads from ptr_q and stalls just hold it.
      ST_READ_FETCH: begin
        if (end_transaction_in) begin
          state_d = ST_IDLE;
        end else begin
          data_d   = mem[ptr_q];
          ptr_d    = ptr_q + PTR_ONE;
          dvalid_d = 1'b1;
          state_d  = ST_READ_DATA;
        end
      end

      ST_READ_DATA: begin
        if (end_transaction_in) begin
          state_d  = ST_IDLE;
          dvalid_d = 1'b0;
          data_d   = '0;
        end else if (!busy_in) begin
          if (rem_q == 8'd0) begin
            state_d  = ST_READ_END;
            dvalid_d = 1'b0;
            data_d   = '0;
            endt_d   = 1'b1;
          end else begin
            data_d = mem[ptr_q];
            ptr_d  = ptr_q + PTR_ONE;
            rem_d  = rem_q - 8'd1;
          end
        end
      end

      ST_READ_END: begin
        endt_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        error_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      be_q     <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
      endt_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      be_q     <= be_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      endt_q   <= endt_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[ptr_q][8*i +: 8] <= address_data_in[8*i +: 8];
      end
    end
  end

  assign address_data_out    = data_q;
  assign data_valid_out      = dvalid_q;
  assign end_transaction_out = endt_q;
  assign busy_out            = busy_q;
  assign error_out           = error_q;

endmodule

// File: tb/tb_dma_bus_responder.sv
// Directed bench for dma_bus_responder: per-cycle vectors of bus inputs and
// the outputs expected right after the clock edge that samples them.
module tb_dma_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        begin_transaction_in;
  logic        end_transaction_in;
  logic        read_n_write_in;
  logic [31:0] address_data_in;
  logic [7:0]  burst_size_in;
  logic [3:0]  byte_enables_in;
  logic        data_valid_in;
  logic        busy_in;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        busy_out;
  logic        error_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dma_bus_responder #(
    .BASE_ADDRESS  (32'h5000_0000),
    .MEM_WORDS_LOG2(8),
    .WAIT_STATES   (2)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in  (end_transaction_in),
    .read_n_write_in     (read_n_write_in),
    .address_data_in     (address_data_in),
    .burst_size_in       (burst_size_in),
    .byte_enables_in     (byte_enables_in),
    .data_valid_in       (data_valid_in),
    .busy_in             (busy_in),
    .address_data_out    (address_data_out),
    .data_valid_out      (data_valid_out),
    .end_transaction_out (end_transaction_out),
    .busy_out            (busy_out),
    .error_out           (error_out)
  );

  typedef struct {
    logic        rst, bt, et, rnw;
    logic [31:0] ad;
    logic [7:0]  bs;
    logic [3:0]  be;
    logic        dv, bi;
    logic [31:0] ado;
    logic        dvo, eto, bo, eo;
  } vec_t;

  function automatic vec_t mk(input logic rst, bt, et, rnw, input logic [31:0] ad,
                              input logic [7:0] bs, input logic [3:0] be, input logic dv, bi,
                              input logic [31:0] ado, input logic dvo, eto, bo, eo);
    vec_t v;
    v.rst = rst; v.bt = bt; v.et = et; v.rnw = rnw; v.ad = ad; v.bs = bs; v.be = be;
    v.dv = dv; v.bi = bi; v.ado = ado; v.dvo = dvo; v.eto = eto; v.bo = bo; v.eo = eo;
    return v;
  endfunction

  function automatic vec_t nop(input logic [31:0] ado, input logic dvo, eto, bo, eo);
    return mk(0, 0, 0, 0, 32'h0, 8'h0, 4'h0, 0, 0, ado, dvo, eto, bo, eo);
  endfunction

  function automatic vec_t beg(input logic rnw, input logic [31:0] ad, input logic [7:0] bs,
                               input logic [3:0] be, input logic eo);
    return mk(0, 1, 0, rnw, ad, bs, be, 0, 0, 32'h0, 0, 0, 0, eo);
  endfunction

  function automatic vec_t wr(input logic [31:0] data, input logic bo, eo);
    return mk(0, 0, 0, 0, data, 8'h0, 4'h0, 1, 0, 32'h0, 0, 0, bo, eo);
  endfunction

  function automatic vec_t rdv(input logic bi, input logic [31:0] ado, input logic dvo, eto);
    return mk(0, 0, 0, 0, 32'h0, 8'h0, 4'h0, 0, bi, ado, dvo, eto, 0, 0);
  endfunction

  function automatic vec_t fin();
    return mk(0, 0, 1, 0, 32'h0, 8'h0, 4'h0, 0, 0, 32'h0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t rstv();
    return mk(1, 0, 0, 0, 32'h0, 8'h0, 4'h0, 0, 0, 32'h0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input vec_t v, input string tag, input int idx);
    logic [35:0] got, exp;
    @(negedge clock);
    reset                = v.rst;
    begin_transaction_in = v.bt;
    end_transaction_in   = v.et;
    read_n_write_in      = v.rnw;
    address_data_in      = v.ad;
    burst_size_in        = v.bs;
    byte_enables_in      = v.be;
    data_valid_in        = v.dv;
    busy_in              = v.bi;
    @(posedge clock);
    #1;
    got = {address_data_out, data_valid_out, end_transaction_out, busy_out, error_out};
    exp = {v.ado, v.dvo, v.eto, v.bo, v.eo};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got ado=%h dv=%b end=%b busy=%b err=%b, want ado=%h dv=%b end=%b busy=%b err=%b",
               tag, idx, address_data_out, data_valid_out, end_transaction_out, busy_out,
               error_out, v.ado, v.dvo, v.eto, v.bo, v.eo);
    end
  endtask

  task automatic run(input vec_t q[$], input string tag);
    for (int i = 0; i < q.size(); i++) apply(q[i], tag, i);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    reset = 1'b1; begin_transaction_in = 1'b0; end_transaction_in = 1'b0;
    read_n_write_in = 1'b0; address_data_in = '0; burst_size_in = '0;
    byte_enables_in = '0; data_valid_in = 1'b0; busy_in = 1'b0;

    // reset state
    tbl.push_back(rstv()); tbl.push_back(rstv());
    // single write then read at word 4
    tbl.push_back(beg(0, 32'h5000_0010, 8'd0, 4'hF, 0));
    tbl.push_back(wr(32'hDEAD_BEEF, 1, 0));
    tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(fin());
    tbl.push_back(beg(1, 32'h5000_0010, 8'd0, 4'hF, 0));
    tbl.push_back(nop(32'hDEAD_BEEF, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    // 4-beat write with 2 wait states; 0x99 offered during busy must be dropped
    tbl.push_back(beg(0, 32'h5000_0000, 8'd3, 4'hF, 0));
    tbl.push_back(wr(32'h11, 1, 0)); tbl.push_back(wr(32'h99, 1, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(wr(32'h22, 1, 0)); tbl.push_back(nop(0, 0, 0, 1, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(wr(32'h33, 1, 0)); tbl.push_back(nop(0, 0, 0, 1, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(wr(32'h44, 1, 0)); tbl.push_back(nop(0, 0, 0, 1, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(fin());
    tbl.push_back(beg(1, 32'h5000_0000, 8'd3, 4'hF, 0));
    tbl.push_back(nop(32'h11, 1, 0, 0, 0)); tbl.push_back(nop(32'h22, 1, 0, 0, 0));
    tbl.push_back(nop(32'h33, 1, 0, 0, 0)); tbl.push_back(nop(32'h44, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1, 0, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    // byte enables: lanes 0 and 2 only
    tbl.push_back(beg(0, 32'h5000_0020, 8'd0, 4'hF, 0));
    tbl.push_back(wr(32'hAABB_CCDD, 1, 0)); tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0)); tbl.push_back(fin());
    tbl.push_back(beg(0, 32'h5000_0020, 8'd0, 4'b0101, 0));
    tbl.push_back(wr(32'h1122_3344, 1, 0)); tbl.push_back(nop(0, 0, 0, 1, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0)); tbl.push_back(fin());
    tbl.push_back(beg(1, 32'h5000_0020, 8'd0, 4'hF, 0));
    tbl.push_back(nop(32'hAA22_CC44, 1, 0, 0, 0));
    tbl.push_back(nop(0, 0, 1, 0, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    // begin errors and in-range boundaries (aborted in READ_FETCH)
    tbl.push_back(beg(1, 32'h5000_0002, 8'd0, 4'hF, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0)); tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(beg(1, 32'h5000_03FC, 8'd1, 4'hF, 1));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(beg(1, 32'h5000_03FC, 8'd0, 4'hF, 0)); tbl.push_back(fin());
    tbl.push_back(beg(1, 32'h5000_0000, 8'd255, 4'hF, 0)); tbl.push_back(fin());
    // misses
    tbl.push_back(beg(1, 32'h6000_0000, 8'd0, 4'hF, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));
    tbl.push_back(beg(0, 32'h4FFF_FFFC, 8'd0, 4'hF, 0));
    tbl.push_back(wr(32'h5555_5555, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0, 0));

    run(tbl, "table");

    // read stall: second beat held for three busy cycles
    seq = {};
    seq.push_back(beg(1, 32'h5000_0000, 8'd3, 4'hF, 0));
    seq.push_back(rdv(0, 32'h11, 1, 0));
    seq.push_back(rdv(0, 32'h22, 1, 0));
    seq.push_back(rdv(1, 32'h22, 1, 0)); seq.push_back(rdv(1, 32'h22, 1, 0));
    seq.push_back(rdv(1, 32'h22, 1, 0));
    seq.push_back(rdv(0, 32'h33, 1, 0)); seq.push_back(rdv(0, 32'h44, 1, 0));
    seq.push_back(rdv(0, 32'h0, 0, 1)); seq.push_back(rdv(0, 32'h0, 0, 0));
    run(seq, "stall");

    // three beats against burst 1; third beat must not reach word 18
    seq = {};
    seq.push_back(beg(0, 32'h5000_0048, 8'd0, 4'hF, 0));
    seq.push_back(wr(32'h1234_5678, 1, 0)); seq.push_back(nop(0, 0, 0, 1, 0));
    seq.push_back(nop(0, 0, 0, 0, 0)); seq.push_back(fin());
    seq.push_back(beg(0, 32'h5000_0040, 8'd1, 4'hF, 0));
    seq.push_back(wr(32'hA0A0_A0A0, 1, 0)); seq.push_back(nop(0, 0, 0, 1, 0)); seq.push_back(nop(0, 0, 0, 0, 0));
    seq.push_back(wr(32'hA1A1_A1A1, 1, 0)); seq.push_back(nop(0, 0, 0, 1, 0)); seq.push_back(nop(0, 0, 0, 0, 0));
    seq.push_back(wr(32'hA2A2_A2A2, 0, 1));
    seq.push_back(nop(0, 0, 0, 0, 0));
    seq.push_back(beg(1, 32'h5000_0040, 8'd2, 4'hF, 0));
    seq.push_back(nop(32'hA0A0_A0A0, 1, 0, 0, 0)); seq.push_back(nop(32'hA1A1_A1A1, 1, 0, 0, 0));
    seq.push_back(nop(32'h1234_5678, 1, 0, 0, 0));
    seq.push_back(nop(0, 0, 1, 0, 0)); seq.push_back(nop(0, 0, 0, 0, 0));
    run(seq, "overrun");

    // read aborted after two beats: no end pulse
    seq = {};
    seq.push_back(beg(1, 32'h5000_0000, 8'd3, 4'hF, 0));
    seq.push_back(nop(32'h11, 1, 0, 0, 0)); seq.push_back(nop(32'h22, 1, 0, 0, 0));
    seq.push_back(fin());
    seq.push_back(nop(0, 0, 0, 0, 0)); seq.push_back(nop(0, 0, 0, 0, 0));
    run(seq, "abort");

    // reset mid-write and mid-read; partial beat survives
    seq = {};
    seq.push_back(beg(0, 32'h5000_0080, 8'd3, 4'hF, 0));
    seq.push_back(wr(32'hB0B0_B0B0, 1, 0));
    seq.push_back(rstv());
    seq.push_back(beg(1, 32'h5000_0080, 8'd0, 4'hF, 0));
    seq.push_back(nop(32'hB0B0_B0B0, 1, 0, 0, 0));
    seq.push_back(nop(0, 0, 1, 0, 0)); seq.push_back(nop(0, 0, 0, 0, 0));
    seq.push_back(beg(1, 32'h5000_0000, 8'd3, 4'hF, 0));
    seq.push_back(nop(32'h11, 1, 0, 0, 0));
    seq.push_back(rstv());
    seq.push_back(nop(0, 0, 0, 0, 0));
    run(seq, "reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
